// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, FSM state encoding and the STATUS word builder.
package uart_tx_mmio_pkg;

  localparam logic [3:0] UART_TXDATA  = 4'h0;
  localparam logic [3:0] UART_STATUS  = 4'h4;
  localparam logic [3:0] UART_DIVISOR = 4'h8;

  localparam int STATUS_BUSY     = 0;
  localparam int STATUS_FULL     = 1;
  localparam int STATUS_EMPTY    = 2;
  localparam int STATUS_OVERFLOW = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic logic [31:0] status_word(input logic overflow, input logic empty,
                                              input logic full, input logic busy);
    logic [31:0] w;
    w = '0;
    w[STATUS_OVERFLOW] = overflow;
    w[STATUS_EMPTY]    = empty;
    w[STATUS_FULL]     = full;
    w[STATUS_BUSY]     = busy;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// CPU data-memory port slice seen by the UART: store/load stream in, read data and hit out.
// No backpressure: a store is valid when I_memrw=1 and the address hits; the UART is always ready.
interface uart_tx_mmio_if;
  logic        I_memrw;
  logic [31:0] I_address;
  logic [31:0] I_data;
  logic [31:0] O_data;
  logic        O_hit;

  modport master (output I_memrw, output I_address, output I_data,
                  input O_data, input O_hit);
  modport slave  (input I_memrw, input I_address, input I_data,
                  output O_data, output O_hit);
endinterface

// File: rtl/uart_tx_mmio_fifo.sv
// Synchronous byte FIFO; a push into a full FIFO is accepted only when a pop happens the same cycle.
module uart_tx_mmio_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic       I_push,
  input  logic       I_pop,
  input  logic [7:0] I_data,
  output logic [7:0] O_data,
  output logic       O_full,
  output logic       O_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  assign O_empty = (count == '0);
  assign O_full  = (count == CW'(DEPTH));
  assign pop_ok  = I_pop && !O_empty;
  assign push_ok = I_push && (!O_full || pop_ok);
  assign O_data  = mem[rd_ptr];

  always_ff @(posedge I_clk) begin
    if (push_ok) mem[wr_ptr] <= I_data;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register decode, DIVISOR/overflow registers,
// TX FSM with baud counter and shift register, fed by a small byte FIFO.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [31:0] BASE         = 32'h0000_1000,
  parameter logic [15:0] CLKDIV_RESET = 16'd867,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic          I_clk,
  input  logic          I_rst,
  uart_tx_mmio_if.slave bus,
  output logic          O_tx,
  output logic          O_busy,
  output uart_state_e   O_state
);
  logic [3:0]  offset;
  logic        hit;
  logic        wr_en;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        unused_data;

  logic [15:0] divisor;
  logic        overflow;

  uart_state_e state, state_n;
  logic        tx_n;
  logic [7:0]  shift, shift_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [15:0] baud, baud_n;

  assign offset      = bus.I_address[3:0];
  assign hit         = (bus.I_address[31:4] == BASE[31:4]);
  assign wr_en       = bus.I_memrw && hit;
  assign push        = wr_en && (offset == UART_TXDATA);
  assign unused_data = ^bus.I_data[31:16];

  assign bus.O_hit = hit;
  assign O_busy    = (state != ST_IDLE) || !fifo_empty;
  assign O_state   = state;

  uart_tx_mmio_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .I_clk   (I_clk),
    .I_rst   (I_rst),
    .I_push  (push),
    .I_pop   (pop),
    .I_data  (bus.I_data[7:0]),
    .O_data  (fifo_data),
    .O_full  (fifo_full),
    .O_empty (fifo_empty)
  );

  always_comb begin
    bus.O_data = '0;
    if (hit) begin
      case (offset)
        UART_STATUS:  bus.O_data = status_word(overflow, fifo_empty, fifo_full, O_busy);
        UART_DIVISOR: bus.O_data = {16'b0, divisor};
        default:      bus.O_data = '0;
      endcase
    end
  end

  // Every bit boundary reloads baud from the live DIVISOR, so a mid-frame
  // DIVISOR write only affects bits that start after it.
  always_comb begin
    state_n   = state;
    tx_n      = O_tx;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    baud_n    = baud;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_data;
          baud_n  = divisor;
          tx_n    = 1'b0;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (baud == '0) begin
          tx_n      = shift[0];
          bit_cnt_n = '0;
          baud_n    = divisor;
          state_n   = ST_DATA;
        end else begin
          baud_n = baud - 16'd1;
        end
      end
      ST_DATA: begin
        if (baud == '0) begin
          baud_n = divisor;
          if (bit_cnt == 3'd7) begin
            tx_n    = 1'b1;
            state_n = ST_STOP;
          end else begin
            shift_n   = {1'b0, shift[7:1]};
            tx_n      = shift[1];
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end else begin
          baud_n = baud - 16'd1;
        end
      end
      ST_STOP: begin
        if (baud == '0) state_n = ST_IDLE;
        else            baud_n  = baud - 16'd1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state    <= ST_IDLE;
      O_tx     <= 1'b1;
      shift    <= '0;
      bit_cnt  <= '0;
      baud     <= '0;
      divisor  <= CLKDIV_RESET;
      overflow <= 1'b0;
    end else begin
      state   <= state_n;
      O_tx    <= tx_n;
      shift   <= shift_n;
      bit_cnt <= bit_cnt_n;
      baud    <= baud_n;
      if (wr_en && offset == UART_DIVISOR) divisor <= bus.I_data[15:0];
      // A dropped byte sets overflow even if a clear lands in the same cycle.
      if (push && fifo_full && !pop)
        overflow <= 1'b1;
      else if (wr_en && offset == UART_STATUS && bus.I_data[STATUS_OVERFLOW])
        overflow <= 1'b0;
    end
  end
endmodule
